// File: rtl/cache_control_nway.sv
// N-way set-associative cache controller: zero-wait hits, tree-PLRU victim choice, write-back/fill miss handling.
// Optional hit/miss performance counters are enabled by defining CACHE_CTRL_PERF_CNT_EN.
//
// state      | meaning
// IDLE       | serve hits in the same cycle, pick a victim on a miss
// WRITE_BACK | write the dirty victim line back to physical memory
// FILL       | read the requested line into the victim way
module cache_control_nway #(
  parameter  int WAYS = 4,
  localparam int WB   = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic            mem_resp,
  input  logic            pmem_resp,
  output logic            pmem_read,
  output logic            pmem_write,
  output logic [31:0]     pmem_mbe,
  input  logic [WAYS-1:0] hit,
  input  logic [WAYS-1:0] valid,
  input  logic [WAYS-1:0] dirty,
  input  logic [WAYS-2:0] plru_out,
  output logic [WAYS-1:0] load_tag,
  output logic [WAYS-1:0] load_valid,
  output logic [WAYS-1:0] load_dirty,
  output logic [WAYS-1:0] load_data,
  output logic [WB-1:0]   way_select,
  output logic            valid_in,
  output logic            dirty_in,
  output logic            data_select,
  output logic            load_plru,
  output logic [WAYS-2:0] plru_in,
  output logic            pmem_addr_sel
`ifdef CACHE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE_BACK, FILL} state_t;

  state_t        r_state;
  logic [WB-1:0] r_vict;

  logic          w_req;
  logic          w_any_hit;
  logic [WB-1:0] w_hit_way;
  logic          w_inv_found;
  logic [WB-1:0] w_inv_way;
  logic [WB-1:0] w_victim;
  logic          w_hit_resp;
  logic          w_miss_go;

  // Walk from the accessed leaf to the root, pointing every node on the path away from it.
  function automatic logic [WAYS-2:0] f_plru_update(input logic [WAYS-2:0] plru, input logic [WB-1:0] way);
    logic [WAYS-2:0] r;
    int n;
    int p;
    r = plru;
    n = int'(way) + WAYS - 1;
    for (int l = 0; l < WB; l++) begin
      p    = (n - 1) / 2;
      r[p] = (n == 2 * p + 1);
      n    = p;
    end
    return r;
  endfunction

  function automatic logic [WB-1:0] f_tree_victim(input logic [WAYS-2:0] plru);
    int n;
    n = 0;
    for (int l = 0; l < WB; l++)
      n = plru[n] ? 2 * n + 2 : 2 * n + 1;
    return WB'(n - (WAYS - 1));
  endfunction

  assign w_req = mem_read | mem_write;

  always_comb begin
    w_any_hit = 1'b0;
    w_hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        w_any_hit = 1'b1;
        w_hit_way = WB'(i);
      end
    end
  end

  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WB'(i);
      end
    end
    w_victim = w_inv_found ? w_inv_way : f_tree_victim(plru_out);
  end

  assign w_hit_resp = (r_state == IDLE) && w_req && w_any_hit;
  assign w_miss_go  = (r_state == IDLE) && w_req && !w_any_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_vict  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss_go) begin
            r_vict  <= w_victim;
            r_state <= (valid[w_victim] && dirty[w_victim]) ? WRITE_BACK : FILL;
          end
        end
        WRITE_BACK: if (pmem_resp) r_state <= FILL;
        FILL:       if (pmem_resp) r_state <= IDLE;
        default:    r_state <= IDLE;
      endcase
    end
  end

  // Outputs are combinational so a hit completes in the cycle it is requested; reset forces them low.
  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_mbe      = '0;
    load_tag      = '0;
    load_valid    = '0;
    load_dirty    = '0;
    load_data     = '0;
    way_select    = '0;
    valid_in      = 1'b0;
    dirty_in      = 1'b0;
    data_select   = 1'b0;
    load_plru     = 1'b0;
    plru_in       = '0;
    pmem_addr_sel = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_hit_resp) begin
            mem_resp   = 1'b1;
            way_select = w_hit_way;
            load_plru  = 1'b1;
            plru_in    = f_plru_update(plru_out, w_hit_way);
            if (mem_write) begin
              load_data[w_hit_way]  = 1'b1;
              load_dirty[w_hit_way] = 1'b1;
              dirty_in              = 1'b1;
              data_select           = 1'b1;
            end
          end
        end
        WRITE_BACK: begin
          pmem_write         = 1'b1;
          pmem_mbe           = 32'hFFFF_FFFF;
          pmem_addr_sel      = 1'b1;
          way_select         = r_vict;
          load_dirty[r_vict] = 1'b1;
        end
        FILL: begin
          pmem_read          = 1'b1;
          way_select         = r_vict;
          load_tag[r_vict]   = 1'b1;
          load_valid[r_vict] = 1'b1;
          load_data[r_vict]  = 1'b1;
          valid_in           = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_CTRL_PERF_CNT_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic        r_after_fill;

  // The hit that completes a miss is flagged by r_after_fill and is not counted as a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_after_fill <= 1'b0;
    end else begin
      r_after_fill <= (r_state == FILL) && pmem_resp;
      if (w_hit_resp && !r_after_fill) r_hit_count <= r_hit_count + 32'd1;
      if (w_miss_go) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  // Counters not built.
`endif

endmodule

// File: tb/tb_cache_control_nway.sv
// Scoreboard bench for cache_control_nway (WAYS=4): directed stimulus pushes expected output vectors,
// a negedge monitor pops and compares whenever the DUT drives mem_resp, pmem_read or pmem_write.
module tb_cache_control_nway;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, mem_write, mem_resp, pmem_resp, pmem_read, pmem_write;
  logic [31:0] pmem_mbe;
  logic [3:0] hit, valid, dirty;
  logic [2:0] plru_out, plru_in;
  logic [3:0] load_tag, load_valid, load_dirty, load_data;
  logic [1:0] way_select;
  logic       valid_in, dirty_in, data_select, load_plru, pmem_addr_sel;
`ifdef CACHE_CTRL_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  cache_control_nway #(.WAYS(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_mbe(pmem_mbe),
    .hit(hit), .valid(valid), .dirty(dirty), .plru_out(plru_out),
    .load_tag(load_tag), .load_valid(load_valid), .load_dirty(load_dirty), .load_data(load_data),
    .way_select(way_select), .valid_in(valid_in), .dirty_in(dirty_in), .data_select(data_select),
    .load_plru(load_plru), .plru_in(plru_in), .pmem_addr_sel(pmem_addr_sel)
`ifdef CACHE_CTRL_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] mbe;
    logic [3:0]  ld_tag;
    logic [3:0]  ld_valid;
    logic [3:0]  ld_dirty;
    logic [3:0]  ld_data;
    logic [1:0]  way;
    logic        valid_in;
    logic        dirty_in;
    logic        data_select;
    logic        load_plru;
    logic [2:0]  plru_in;
    logic        addr_sel;
  } obs_t;

  typedef struct {
    obs_t  o;
    string name;
  } exp_t;

  obs_t w_obs;
  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  assign w_obs = '{mem_resp, pmem_read, pmem_write, pmem_mbe, load_tag, load_valid, load_dirty,
                   load_data, way_select, valid_in, dirty_in, data_select, load_plru, plru_in,
                   pmem_addr_sel};

  function automatic obs_t o_hit(input int w, input bit wr, input logic [2:0] p);
    obs_t o;
    o = '0;
    o.mem_resp  = 1'b1;
    o.way       = 2'(w);
    o.load_plru = 1'b1;
    o.plru_in   = p;
    if (wr) begin
      o.ld_data[w]  = 1'b1;
      o.ld_dirty[w] = 1'b1;
      o.dirty_in    = 1'b1;
      o.data_select = 1'b1;
    end
    return o;
  endfunction

  function automatic obs_t o_wb(input int w);
    obs_t o;
    o = '0;
    o.pmem_write  = 1'b1;
    o.mbe         = 32'hFFFF_FFFF;
    o.addr_sel    = 1'b1;
    o.way         = 2'(w);
    o.ld_dirty[w] = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_fill(input int w);
    obs_t o;
    o = '0;
    o.pmem_read   = 1'b1;
    o.way         = 2'(w);
    o.ld_tag[w]   = 1'b1;
    o.ld_valid[w] = 1'b1;
    o.ld_data[w]  = 1'b1;
    o.valid_in    = 1'b1;
    return o;
  endfunction

  task automatic push(input obs_t o, input string name);
    exp_t x;
    x.o    = o;
    x.name = name;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input logic [3:0] h, input logic [3:0] v, input logic [3:0] d, input logic [2:0] p);
    hit = h; valid = v; dirty = d; plru_out = p;
  endtask

  always @(negedge clk) begin
    if (!rst && (mem_resp || pmem_read || pmem_write)) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h expected no activity", w_obs);
      end else begin
        e = q.pop_front();
        if (w_obs !== e.o) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, w_obs, e.o);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; pmem_resp = 1'b0;
    status(4'b0001, 4'b1111, 4'b0000, 3'b000);
    #2;
    chk("reset_outputs_zero", 64'(w_obs), 64'd0);
    step(); step();
    mem_read = 1'b0; hit = 4'b0000;
    rst = 1'b0;
    step();

    // Read miss with every way invalid: fill way 0, then hit one cycle after pmem_resp.
    status(4'b0000, 4'b0000, 4'b0000, 3'b000); mem_read = 1'b1;
    step();
    push(o_fill(0), "miss_fill_w0_c0"); step();
    push(o_fill(0), "miss_fill_w0_c1"); step();
    pmem_resp = 1'b1; push(o_fill(0), "miss_fill_w0_c2"); step();
    pmem_resp = 1'b0; status(4'b0001, 4'b0001, 4'b0000, 3'b000);
    push(o_hit(0, 0, 3'b011), "miss_then_hit_w0"); step();
    mem_read = 1'b0; step();

    // Write hit way 2, read also asserted: write wins, root cleared, node2 set.
    status(4'b0100, 4'b1111, 4'b0000, 3'b011); mem_write = 1'b1; mem_read = 1'b1;
    push(o_hit(2, 1, 3'b110), "write_hit_w2"); step();
    mem_write = 1'b0; mem_read = 1'b0; step();

    // Two hit bits: lowest index wins.
    status(4'b1010, 4'b1111, 4'b0000, 3'b110); mem_read = 1'b1;
    push(o_hit(1, 0, 3'b101), "multi_hit_w1"); step();
    status(4'b1000, 4'b1111, 4'b0000, 3'b111);
    push(o_hit(3, 0, 3'b010), "read_hit_w3"); step();
    mem_read = 1'b0; step();

    // Dirty PLRU victim way 2: write back, then fill; status toggled to prove the victim is latched.
    status(4'b0000, 4'b1111, 4'b0100, 3'b001); mem_read = 1'b1;
    step();
    status(4'b0000, 4'b1111, 4'b0000, 3'b000);
    push(o_wb(2), "wb_w2_c0"); step();
    pmem_resp = 1'b1; push(o_wb(2), "wb_w2_c1"); step();
    pmem_resp = 1'b0; status(4'b0000, 4'b0001, 4'b1111, 3'b110);
    push(o_fill(2), "fill_w2_c0"); step();
    status(4'b0000, 4'b0000, 4'b0000, 3'b000);
    push(o_fill(2), "fill_w2_c1"); step();
    pmem_resp = 1'b1; status(4'b0000, 4'b1110, 4'b0001, 3'b111);
    push(o_fill(2), "fill_w2_c2"); step();
    pmem_resp = 1'b0; status(4'b0100, 4'b1111, 4'b0000, 3'b001);
    push(o_hit(2, 0, 3'b100), "wb_fill_then_hit_w2"); step();
    mem_read = 1'b0; hit = 4'b0000; step();

    // Lowest invalid way beats PLRU; request dropped mid-miss must not produce mem_resp.
    status(4'b0000, 4'b1101, 4'b1111, 3'b000); mem_write = 1'b1;
    step();
    mem_write = 1'b0;
    push(o_fill(1), "abort_fill_w1_c0"); step();
    pmem_resp = 1'b1; push(o_fill(1), "abort_fill_w1_c1"); step();
    pmem_resp = 1'b0; status(4'b0010, 4'b1111, 4'b0000, 3'b000);
    step(); step();

    // Clean PLRU victim way 3 goes straight to fill with a one-cycle pmem_resp.
    status(4'b0000, 4'b1111, 4'b0000, 3'b101); mem_read = 1'b1;
    step();
    pmem_resp = 1'b1; push(o_fill(3), "clean_fill_w3"); step();
    pmem_resp = 1'b0; status(4'b1000, 4'b1111, 4'b0000, 3'b101);
    push(o_hit(3, 0, 3'b000), "clean_fill_then_hit_w3"); step();
    mem_read = 1'b0; hit = 4'b0000; step();

    // Reset in the middle of a write-back.
    status(4'b0000, 4'b1111, 4'b1111, 3'b000); mem_read = 1'b1;
    step();
    push(o_wb(0), "wb_w0_before_rst");
`ifdef CACHE_CTRL_PERF_CNT_EN
    chk("hit_count_before_rst", 64'(hit_count), 64'd3);
    chk("miss_count_before_rst", 64'(miss_count), 64'd5);
`endif
    step();
    rst = 1'b1;
    #1;
    chk("rst_drops_pmem_write", 64'(pmem_write), 64'd0);
    chk("rst_all_outputs_zero", 64'(w_obs), 64'd0);
`ifdef CACHE_CTRL_PERF_CNT_EN
    chk("hit_count_after_rst", 64'(hit_count), 64'd0);
    chk("miss_count_after_rst", 64'(miss_count), 64'd0);
`endif
    mem_read = 1'b0;
    step();
    rst = 1'b0;
    step();
    status(4'b0001, 4'b1111, 4'b0000, 3'b000); mem_read = 1'b1;
    push(o_hit(0, 0, 3'b011), "idle_after_rst_hit_w0"); step();
    mem_read = 1'b0; hit = 4'b0000;
    step(); step();

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_control_nway.md
CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity; legal values 2, 4, 8.
REQ-002 SHALL derive localparam WB = $clog2(WAYS), way index width.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 mem_read, mem_write  in  1 each  CPU request, held until mem_resp.
REQ-006 mem_resp  out  1  CPU response, one-cycle pulse per request.
REQ-007 pmem_resp  in  1  physical memory done.
REQ-008 pmem_read, pmem_write  out  1 each  physical memory request.
REQ-009 pmem_mbe  out  32  physical write byte enable.
REQ-010 hit, valid, dirty  in  WAYS each  per-way status for current set.
REQ-011 plru_out  in  WAYS-1  tree-PLRU bits for current set.
REQ-012 load_tag, load_valid, load_dirty, load_data  out  WAYS each  per-way array write enables.
REQ-013 way_select  out  WB  way driving data/tag muxes.
REQ-014 valid_in, dirty_in, data_select  out  1 each  array write data controls (data_select 1 = CPU wdata).
REQ-015 load_plru  out  1; plru_in  out  WAYS-1  PLRU update.
REQ-016 pmem_addr_sel  out  1  0 = {CPU tag,index,5'd0}; 1 = {tag[way_select],index,5'd0}.

Function
REQ-017 SHALL implement states IDLE, WRITE_BACK, FILL.
REQ-018 All outputs SHALL default to 0 in every state unless stated.
REQ-019 IDLE, request with hit[w]: mem_resp=1, way_select=w, load_plru=1, plru_in = plru_out with path to w updated, same cycle (zero-wait hit).
REQ-020 Write hit SHALL additionally assert load_data[w], load_dirty[w], dirty_in=1, data_select=1; mem_write takes priority over mem_read.
REQ-021 More than one hit bit set SHALL select lowest index.
REQ-022 PLRU tree: node i children 2i+1/2i+2, bit 0 = victim in left subtree; access sets each path node to point away from accessed way.
REQ-023 Victim SHALL be lowest-index invalid way, else way reached by following plru_out from root.
REQ-024 IDLE miss SHALL latch victim into register vict; go WRITE_BACK if valid[victim]&dirty[victim], else FILL; no request -> stay IDLE.
REQ-025 WRITE_BACK: pmem_write=1, pmem_mbe=32'hFFFFFFFF, pmem_addr_sel=1, way_select=vict, load_dirty[vict]=1, dirty_in=0; on pmem_resp -> FILL.
REQ-026 FILL: pmem_read=1, pmem_addr_sel=0, way_select=vict, load_tag/load_valid/load_data[vict]=1, valid_in=1; on pmem_resp -> IDLE.
REQ-027 After FILL, request SHALL be re-evaluated in IDLE and complete as hit; miss latency = fill + 1 cycle.
REQ-028 vict SHALL hold stable throughout WRITE_BACK and FILL regardless of status input changes.
REQ-029 Request deasserted mid-miss SHALL NOT abort; transaction completes, no mem_resp issued.

Reset
REQ-030 rst SHALL asynchronously force state=IDLE, vict=0, counters=0; all outputs 0 while rst high.
REQ-031 rst during WRITE_BACK/FILL SHALL drop pmem_read/pmem_write immediately.

Configuration
REQ-032 Macro CACHE_CTRL_PERF_CNT_EN defined: outputs hit_count, miss_count (32 bits each), wrapping; hit_count +1 per hit-response cycle not preceded by miss, miss_count +1 per IDLE->WRITE_BACK/FILL transition.
REQ-033 Macro undefined: counter ports and logic absent; behaviour otherwise identical.

Verification (WAYS=4)
REQ-034 Reset, read miss all invalid -> vict=0, FILL, pmem_read until pmem_resp, then mem_resp next cycle with hit[0].
REQ-035 Write hit hit=4'b0100 -> mem_resp, load_data[2], load_dirty[2], dirty_in=1, plru_in root=0, node2=1 same cycle.
REQ-036 All valid, plru_out=3'b001 (root 1, node2 0), dirty[2]=1, miss -> WRITE_BACK, pmem_addr_sel=1, way_select=2, then FILL way 2.
REQ-037 Status inputs toggled during FILL -> way_select constant, load enables only on latched way.
REQ-038 rst pulsed mid-WRITE_BACK -> pmem_write low same cycle, state IDLE; with CACHE_CTRL_PERF_CNT_EN counters read 0.
